// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared image-geometry constants for the pixel pipeline: pixel width, frame
// size and the framing counter widths derived from them. Blocks that can be
// resized take these as parameter defaults.
// -----------------------------------------------------------------------------
package img_pkg;

  localparam int PIX_W = 8;
  localparam int IMG_W = 512;
  localparam int IMG_H = 512;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  // Fill level after one cycle of optional push and pop.
  function automatic int fill_after(input int fill, input logic push, input logic pop);
    return fill + int'(push) - int'(pop);
  endfunction

endpackage : img_pkg

// File: rtl/px_sync_fifo.sv
// -----------------------------------------------------------------------------
// px_sync_fifo
// DEPTH x PIX_W synchronous FIFO with show-ahead read data. Pointers carry an
// extra wrap bit so full and empty are distinguished without a separate flag.
// The caller must not push when full unless it also pops in the same cycle,
// and must not pop when empty.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wr_en_i       push wr_data_i this cycle
//   wr_data_i     pixel to store
//   rd_en_i       pop the head this cycle
//   rd_data_o     current head (valid while !empty_o)
//   count_o       number of stored entries, 0..DEPTH
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
// -----------------------------------------------------------------------------
module px_sync_fifo #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [PIX_W-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [PIX_W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // NOTE: the storage array has no reset; stale contents are never visible
  // because empty_o is derived from the pointers, and leaving it unreset lets
  // it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(0) + (AW+1)'(wr_en_i);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule : px_sync_fifo

// File: rtl/pixel_stream_packer.sv
// -----------------------------------------------------------------------------
// pixel_stream_packer
// Absorbs a free-running filtered pixel stream into an elastic FIFO and
// presents it as a valid/ready master with line/frame framing.
//
// Ports:
//   axi_clk, axi_reset_n   clock, asynchronous active-low reset
//   i_data_valid, i_data   upstream pixel, sampled every cycle valid is high
//   o_data_ready           registered advisory ready (FIFO not almost full)
//   o_data_valid, o_data   downstream beat
//   o_last                 last pixel of a line
//   o_sof                  first pixel of a frame
//   i_data_ready           downstream ready
//   o_frame_done           one-cycle pulse after the final beat of a frame
//   o_overflow             sticky: a pixel was dropped on a full FIFO
//
// Total buffering is DEPTH FIFO entries plus the output register.
// -----------------------------------------------------------------------------
module pixel_stream_packer #(
  parameter int PIX_W        = img_pkg::PIX_W,
  parameter int DEPTH        = 16,
  parameter int IMG_W        = img_pkg::IMG_W,
  parameter int IMG_H        = img_pkg::IMG_H,
  parameter int AFULL_MARGIN = 4
) (
  input  logic             axi_clk,
  input  logic             axi_reset_n,
  input  logic             i_data_valid,
  input  logic [PIX_W-1:0] i_data,
  output logic             o_data_ready,
  output logic             o_data_valid,
  output logic [PIX_W-1:0] o_data,
  output logic             o_last,
  output logic             o_sof,
  input  logic             i_data_ready,
  output logic             o_frame_done,
  output logic             o_overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // FIFO interface
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  logic [PIX_W-1:0] fifo_head;
  logic             push, pop, drop;

  // Registered state
  logic             valid_q, valid_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  logic             beat_accept;
  logic             frame_end;

  assign beat_accept = valid_q && i_data_ready;

  // Refill the output register whenever it is empty or being drained.
  assign pop  = !fifo_empty && (!valid_q || i_data_ready);
  // A full FIFO still takes a pixel when a slot frees in the same cycle.
  assign push = i_data_valid && (!fifo_full || pop);
  assign drop = i_data_valid && fifo_full && !pop;

  assign frame_end = beat_accept && (col_q == COL_LAST) && (row_q == ROW_LAST);

  px_sync_fifo #(
    .PIX_W (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (axi_clk),
    .rst_n     (axi_reset_n),
    .wr_en_i   (push),
    .wr_data_i (i_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = frame_end;
    overflow_d   = overflow_q | drop;
    // Ready looks one cycle ahead: it reflects the fill after this edge.
    ready_d      = img_pkg::fill_after(int'(fifo_count), push, pop) < (DEPTH - AFULL_MARGIN);

    if (pop) begin
      valid_d = 1'b1;
      data_d  = fifo_head;
    end else if (beat_accept) begin
      valid_d = 1'b0;
    end

    if (beat_accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_data_ready = ready_q;
  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_last       = valid_q && (col_q == COL_LAST);
  assign o_sof        = valid_q && (col_q == '0) && (row_q == '0);
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;

endmodule : pixel_stream_packer

// File: tb/tb_pixel_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_packer
// Directed bench for pixel_stream_packer, built with a small 8x4 frame so
// whole frames fit in a short run. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pixel_stream_packer;

  localparam int PIX_W  = 8;
  localparam int DEPTH  = 16;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int MARGIN = 4;
  localparam int FRAME  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             up_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_last;
  logic             out_sof;
  logic             ds_ready;
  logic             frame_done;
  logic             overflow;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pixel_stream_packer #(
    .PIX_W        (PIX_W),
    .DEPTH        (DEPTH),
    .IMG_W        (IMG_W),
    .IMG_H        (IMG_H),
    .AFULL_MARGIN (MARGIN)
  ) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .i_data_valid (in_valid),
    .i_data       (in_data),
    .o_data_ready (up_ready),
    .o_data_valid (out_valid),
    .o_data       (out_data),
    .o_last       (out_last),
    .o_sof        (out_sof),
    .i_data_ready (ds_ready),
    .o_frame_done (frame_done),
    .o_overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ds_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PIX_W-1:0] exp_q [$];
    int sent, recv, n_last, n_sof, n_done;
    logic exp_done, acc;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ds_ready = 1'b0;

    // ---- Reset state and release --------------------------------------
    @(negedge clk);
    check("rst_ready",    up_ready,   0);
    check("rst_valid",    out_valid,  0);
    check("rst_data",     out_data,   0);
    check("rst_last",     out_last,   0);
    check("rst_sof",      out_sof,    0);
    check("rst_done",     frame_done, 0);
    check("rst_overflow", overflow,   0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", up_ready, 0);
    step();
    check("ready_after_edge", up_ready,  1);
    check("idle_valid",       out_valid, 0);
    step();
    check("idle_valid2",      out_valid, 0);

    // ---- Stream 0x00..0x0F, downstream always ready --------------------
    ds_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 16);
      in_data  = PIX_W'(c);
      step();
      if (c >= 1 && c <= 16) begin
        check("stream_valid", out_valid, 1);
        check("stream_data",  out_data,  c - 1);
        check("stream_sof",   out_sof,   (c - 1) == 0);
        check("stream_last",  out_last,  ((c - 1) % IMG_W) == IMG_W - 1);
      end else begin
        check("stream_idle", out_valid, 0);
      end
    end
    in_valid = 1'b0;

    // ---- Mid-stream reset with 5 pixels buffered -----------------------
    // 16 beats consumed so framing now sits at row 2, col 0.
    ds_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = PIX_W'(8'hA0 + k);
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data",  out_data,  8'hA0);
    check("pre_rst_sof",   out_sof,   0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", up_ready,  0);
    check("async_rst_data",  out_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", up_ready, 1);
    ds_ready = 1'b1;
    step();
    check("post_rst_empty", out_valid, 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data",  out_data,  8'h5A);
    check("post_rst_sof",   out_sof,   1);
    step();
    check("post_rst_drained", out_valid, 0);

    // ---- Fill to capacity, then overflow -------------------------------
    do_reset();
    ds_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data  = PIX_W'(8'h40 + k);
      step();
      if (k == 11) check("afull_ready_hi", up_ready, 1);
      if (k == 12) check("afull_ready_lo", up_ready, 0);
    end
    check("full_no_overflow", overflow, 0);
    check("full_ready",       up_ready, 0);
    in_data = 8'hEE;
    step();
    in_valid = 1'b0;
    check("overflow_set", overflow, 1);
    ds_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data",  out_data,  8'h40 + i);
      if (i == 0) check("drain_sof", out_sof, 1);
      step();
    end
    check("drain_empty",      out_valid, 0);
    check("overflow_sticky",  overflow,  1);
    check("drain_ready_back", up_ready,  1);

    // ---- Full storage with simultaneous write and accepted read --------
    do_reset();
    check("ovf_cleared", overflow, 0);
    ds_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data  = PIX_W'(8'h60 + k);
      step();
    end
    check("simul_head", out_data, 8'h60);
    in_data  = 8'h71;
    ds_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("simul_no_overflow", overflow, 0);
    check("simul_ready_low",   up_ready, 0);
    for (int i = 0; i < 17; i++) begin
      check("simul_valid", out_valid, 1);
      check("simul_data",  out_data,  8'h61 + i);
      step();
    end
    check("simul_empty",    out_valid, 0);
    check("simul_overflow", overflow,  0);

    // ---- Two back-to-back frames, random handshakes --------------------
    do_reset();
    sent = 0; recv = 0; n_last = 0; n_sof = 0; n_done = 0;
    exp_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && recv < 2 * FRAME; cyc++) begin
      check("frm_done", frame_done, exp_done);
      if (frame_done) n_done++;
      if (out_valid) begin
        check("frm_data", out_data, (exp_q.size() > 0) ? exp_q[0] : 8'hXX);
        check("frm_last", out_last, (recv % IMG_W) == IMG_W - 1);
        check("frm_sof",  out_sof,  (recv % FRAME) == 0);
      end
      ds_ready = ($urandom_range(0, 3) != 0);
      acc      = out_valid && ds_ready;
      exp_done = acc && ((recv % FRAME) == FRAME - 1);
      if (acc) begin
        if (out_last) n_last++;
        if (out_sof)  n_sof++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        recv++;
      end
      in_valid = up_ready && (sent < 2 * FRAME) && ($urandom_range(0, 3) != 0);
      in_data  = PIX_W'($urandom_range(0, 255));
      if (in_valid) begin
        exp_q.push_back(in_data);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    ds_ready = 1'b0;
    check("frm_done_last", frame_done, exp_done);
    if (frame_done) n_done++;
    step();
    check("frm_done_pulse", frame_done, 0);
    check("frm_beats",      recv,       2 * FRAME);
    check("frm_last_count", n_last,     2 * IMG_H);
    check("frm_sof_count",  n_sof,      2);
    check("frm_done_count", n_done,     2);
    check("frm_overflow",   overflow,   0);
    check("frm_idle",       out_valid,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pixel_stream_packer
